// File: rtl/risc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | risc_pkg : widths shared by the PC datapath and the return stack |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package risc_pkg;
  localparam int PC_W     = 8;
  localparam int RS_DEPTH = 8;
endpackage
`default_nettype wire

// File: rtl/return_stack_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | return_stack_if : decoder-side call/return bus and stack status  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface return_stack_if
  import risc_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RS_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              call_en;
  logic              ret_en;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_load_en;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output call_en, ret_en, pc_in,
    input  ret_addr, ret_load_en, empty, full, count, overflow, underflow
  );

  modport slave (
    input  call_en, ret_en, pc_in,
    output ret_addr, ret_load_en, empty, full, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/rs_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rs_mem : stack storage, one sync write port, one async read port |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rs_mem
  import risc_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RS_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);
  logic [ADDR_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; sp alone decides what is valid.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | return_stack : call/return address stack feeding the PC load mux |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module return_stack
  import risc_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = RS_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  return_stack_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  r_sp;
  logic [CNT_W-1:0]  w_sp_m1;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_replace;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [IDX_W-1:0]  w_raddr;
  logic [ADDR_W-1:0] w_rdata;
  logic [ADDR_W-1:0] w_push_data;
  logic [ADDR_W-1:0] r_ret_addr;
  logic              r_ret_load_en;
  logic              r_overflow;
  logic              r_underflow;

  assign w_empty     = (r_sp == '0);
  assign w_full      = (r_sp == CNT_W'(DEPTH));
  assign w_sp_m1     = r_sp - CNT_W'(1);
  assign w_push_data = bus.pc_in + ADDR_W'(1);

  // A call alongside a valid return overwrites the top entry in place;
  // a call alongside a return on an empty stack is an ordinary push.
  assign w_pop     = bus.ret_en && !w_empty;
  assign w_replace = bus.call_en && w_pop;
  assign w_push    = bus.call_en && !w_pop && !w_full;
  assign w_we      = w_push || w_replace;
  assign w_raddr   = w_sp_m1[IDX_W-1:0];
  assign w_waddr   = w_replace ? w_sp_m1[IDX_W-1:0] : r_sp[IDX_W-1:0];

  rs_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_push_data),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sp          <= '0;
      r_ret_addr    <= '0;
      r_ret_load_en <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_ret_load_en <= w_pop;
      if (w_pop) r_ret_addr <= w_rdata;

      if (w_push)                     r_sp <= r_sp + CNT_W'(1);
      else if (w_pop && !bus.call_en) r_sp <= w_sp_m1;

      if (bus.call_en && !bus.ret_en && w_full) r_overflow  <= 1'b1;
      if (bus.ret_en && w_empty)                r_underflow <= 1'b1;
    end
  end

  assign bus.ret_addr    = r_ret_addr;
  assign bus.ret_load_en = r_ret_load_en;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.count       = r_sp;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_return_stack : directed + random bench with a queue model     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_return_stack;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  return_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) rs_bus ();

  return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rs_bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // Reference model: a queue whose back is the stack top.
  logic [ADDR_W-1:0] stk[$];
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_load = 1'b0;
  logic              m_ov   = 1'b0;
  logic              m_un   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input logic c, input logic r, input logic [ADDR_W-1:0] pc, input logic rn);
    logic [ADDR_W-1:0] nxt;
    nxt = pc + 8'd1;
    if (!rn) begin
      stk.delete();
      m_addr = '0; m_load = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      m_load = 1'b0;
      if (r && stk.size() > 0) begin
        m_addr = stk.pop_back();
        m_load = 1'b1;
        if (c) stk.push_back(nxt);
      end else begin
        if (r) m_un = 1'b1;
        if (c) begin
          if (stk.size() == DEPTH) m_ov = 1'b1;
          else stk.push_back(nxt);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},     32'(rs_bus.count),     32'(stk.size()));
    check({tag, ".empty"},     32'(rs_bus.empty),     32'(stk.size() == 0));
    check({tag, ".full"},      32'(rs_bus.full),      32'(stk.size() == DEPTH));
    check({tag, ".ret_addr"},  32'(rs_bus.ret_addr),  32'(m_addr));
    check({tag, ".ret_load"},  32'(rs_bus.ret_load_en), 32'(m_load));
    check({tag, ".overflow"},  32'(rs_bus.overflow),  32'(m_ov));
    check({tag, ".underflow"}, 32'(rs_bus.underflow), 32'(m_un));
  endtask

  // Drive one cycle, advance the model, then sample 1 ns after the edge.
  task automatic step(input string tag, input logic c, input logic r,
                      input logic [ADDR_W-1:0] pc, input logic rn);
    rs_bus.call_en = c;
    rs_bus.ret_en  = r;
    rs_bus.pc_in   = pc;
    reset          = rn;
    @(posedge clk);
    model(c, r, pc, rn);
    #1;
    check_all(tag);
  endtask

  initial begin
    rs_bus.call_en = 1'b0;
    rs_bus.ret_en  = 1'b0;
    rs_bus.pc_in   = '0;

    // Reset and idle
    step("rst", 0, 0, 8'h00, 0);
    step("idle", 0, 0, 8'h00, 1);
    check("idle_addr", 32'(rs_bus.ret_addr), 32'h00);
    check("idle_empty", 32'(rs_bus.empty), 32'd1);

    // Three calls then three returns, LIFO on consecutive cycles
    step("c10", 1, 0, 8'h10, 1);
    step("c20", 1, 0, 8'h20, 1);
    step("c30", 1, 0, 8'h30, 1);
    step("r1", 0, 1, 8'h00, 1);
    check("lifo1", 32'(rs_bus.ret_addr), 32'h31);
    step("r2", 0, 1, 8'h00, 1);
    check("lifo2", 32'(rs_bus.ret_addr), 32'h21);
    step("r3", 0, 1, 8'h00, 1);
    check("lifo3", 32'(rs_bus.ret_addr), 32'h11);
    check("lifo3_load", 32'(rs_bus.ret_load_en), 32'd1);
    check("lifo_empty", 32'(rs_bus.empty), 32'd1);

    // Fill to DEPTH, then overflow
    step("rst2", 0, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      step("fill", 1, 0, 8'(i), 1);
      if (i == 7) check("full_at8", 32'(rs_bus.full), 32'd1);
    end
    check("ovf_flag", 32'(rs_bus.overflow), 32'd1);
    check("ovf_count", 32'(rs_bus.count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step("drain", 0, 1, 8'h00, 1);
      check("drain_addr", 32'(rs_bus.ret_addr), 32'(8 - i));
    end

    // Underflow at reset-empty, sticky through pushes
    step("rst3", 0, 0, 8'h00, 0);
    step("unf", 0, 1, 8'h00, 1);
    check("unf_flag", 32'(rs_bus.underflow), 32'd1);
    check("unf_load", 32'(rs_bus.ret_load_en), 32'd0);
    check("unf_addr", 32'(rs_bus.ret_addr), 32'h00);
    step("unf_p1", 1, 0, 8'h55, 1);
    step("unf_p2", 1, 0, 8'h66, 1);
    check("unf_sticky", 32'(rs_bus.underflow), 32'd1);

    // Wrap of pc+1 and simultaneous call/return
    step("rst4", 0, 0, 8'h00, 0);
    step("cFF", 1, 0, 8'hFF, 1);
    step("swap", 1, 1, 8'h40, 1);
    check("swap_addr", 32'(rs_bus.ret_addr), 32'h00);
    check("swap_load", 32'(rs_bus.ret_load_en), 32'd1);
    check("swap_count", 32'(rs_bus.count), 32'd1);
    step("swap_pop", 0, 1, 8'h00, 1);
    check("swap_pop_addr", 32'(rs_bus.ret_addr), 32'h41);

    // Simultaneous call/return on empty pushes and flags underflow
    step("rst5", 0, 0, 8'h00, 0);
    step("both_empty", 1, 1, 8'h70, 1);
    check("both_empty_cnt", 32'(rs_bus.count), 32'd1);

    // Reset overrides a return in the same cycle
    step("rst6", 0, 0, 8'h00, 0);
    step("p_a", 1, 0, 8'h01, 1);
    step("p_b", 1, 0, 8'h02, 1);
    step("rst_ret", 0, 1, 8'h00, 0);
    check("rst_ret_cnt", 32'(rs_bus.count), 32'd0);
    check("rst_ret_load", 32'(rs_bus.ret_load_en), 32'd0);
    step("post_rst", 0, 0, 8'h00, 1);

    // Random traffic: push-biased phase, then pop-biased phase
    for (int i = 0; i < 400; i++) begin
      logic c, r, rn;
      int   pcall;
      pcall = (i < 200) ? 70 : 30;
      c  = ($urandom_range(0, 99) < pcall);
      r  = ($urandom_range(0, 99) < (100 - pcall));
      rn = ($urandom_range(0, 59) != 0);
      step("rand", c, r, 8'($urandom), rn);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
`default_nettype wire
